// File: rtl/pipelined_adder_param.sv
// Pipelined WIDTH-bit add/subtract built from STAGES carry-chained slices with
// valid/ready back-pressure, returning carry, signed-overflow and zero flags.
module pipelined_adder_param #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp0,
  input  logic [WIDTH-1:0] inp1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("pipelined_adder_param: WIDTH must be a non-zero multiple of STAGES");
  end

  // Per-stage registers; a_r/b_r carry the operands forward so every
  // transaction travels through the pipe as one unit.
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];
  logic [WIDTH-1:0]  sum_r [STAGES];
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] v_r;
  logic              ovf_r;
  logic              zero_r;

  logic [STAGES-1:0] adv_s;
  logic [WIDTH-1:0]  a_src_s   [STAGES];
  logic [WIDTH-1:0]  b_src_s   [STAGES];
  logic [WIDTH-1:0]  sum_src_s [STAGES];
  logic [WIDTH-1:0]  sum_nx_s  [STAGES];
  logic [SW:0]       slice_s   [STAGES];
  logic [STAGES-1:0] c_src_s;
  logic [STAGES-1:0] c_nx_s;
  logic [STAGES-1:0] v_src_s;
  logic              ovf_nx_s;
  logic              zero_nx_s;

  // Back-pressure chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    adv_s       = '0;
    adv_s[LAST] = !v_r[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv_s[k] = !v_r[k] || adv_s[k + 1];
    end
  end

  // Stage inputs and slice arithmetic; stage 0 sees the prepared operands directly.
  always_comb begin
    c_src_s = '0;
    v_src_s = '0;
    c_nx_s  = '0;
    a_src_s[0]   = inp0;
    b_src_s[0]   = sub ? ~inp1 : inp1;
    c_src_s[0]   = sub ? ~cin : cin;
    sum_src_s[0] = '0;
    v_src_s[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src_s[k]   = a_r[k - 1];
      b_src_s[k]   = b_r[k - 1];
      c_src_s[k]   = c_r[k - 1];
      sum_src_s[k] = sum_r[k - 1];
      v_src_s[k]   = v_r[k - 1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_s[k] = {1'b0, a_src_s[k][k*SW +: SW]}
                 + {1'b0, b_src_s[k][k*SW +: SW]}
                 + {{SW{1'b0}}, c_src_s[k]};
      sum_nx_s[k]              = sum_src_s[k];
      sum_nx_s[k][k*SW +: SW]  = slice_s[k][SW-1:0];
      c_nx_s[k]                = slice_s[k][SW];
    end
    // Flags use the operand MSBs that travelled with the transaction.
    ovf_nx_s  = (a_src_s[LAST][WIDTH-1] == b_src_s[LAST][WIDTH-1]) &&
                (sum_nx_s[LAST][WIDTH-1] != a_src_s[LAST][WIDTH-1]);
    zero_nx_s = ~|sum_nx_s[LAST];
  end

  // Pipeline registers: valid moves on advance, data only when a valid beat loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r    <= '0;
      c_r    <= '0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        sum_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv_s[k]) begin
          v_r[k] <= v_src_s[k];
          if (v_src_s[k]) begin
            a_r[k]   <= a_src_s[k];
            b_r[k]   <= b_src_s[k];
            sum_r[k] <= sum_nx_s[k];
            c_r[k]   <= c_nx_s[k];
          end
        end
      end
      if (adv_s[LAST] && v_src_s[LAST]) begin
        ovf_r  <= ovf_nx_s;
        zero_r <= zero_nx_s;
      end
    end
  end

  assign in_ready  = adv_s[0];
  assign out_valid = v_r[LAST];
  assign sum       = sum_r[LAST];
  assign carry     = c_r[LAST];
  assign overflow  = ovf_r;
  assign zero      = zero_r;

endmodule
